csr_exec_unit: RTL
==================

Name: csr_exec_unit

Overview:
Executes Zicsr instructions (CSRRW/RS/RC and immediate forms) on behalf of the commit stage. It sits directly upstream of the CSR register file and drives that file's read port (raddr/rdata) and write port (waddr/we/wdata). The unit applies read-modify-write semantics and privilege and read-only legality checks, returns the old CSR value for rd, and raises either a pipeline flush/redirect to pc+4 or an illegal-instruction exception.

Parameters:
XLEN, 32, data/CSR width
ILLEGAL_CAUSE, 2, mcause code reported for illegal CSR access

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  CSR instruction offered
in_ready  out  1  unit can accept (high only in IDLE)
in_funct3  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
in_csr  in  12  CSR address
in_rs1_idx  in  5  rs1 index / zimm
in_rs1_val  in  XLEN  rs1 value
in_rd_idx  in  5  destination register
in_pc  in  XLEN  instruction PC
in_inst  in  32  raw instruction, used as tval
cpu_mode  in  2  current privilege (0 U, 1 S, 3 M)
kill  in  1  abort in-flight op
csr_raddr  out  12  to CSR file read port
csr_rdata  in  XLEN  combinational read data
csr_waddr  out  12  to CSR file write port
csr_we  out  1  write strobe
csr_wdata  out  XLEN  write data
out_valid  out  1  result available
out_ready  in  1  writeback accepts
out_rd_idx  out  5  destination
out_rd_we  out  1  write rd (rd!=0 and no exception)
out_rd_data  out  XLEN  old CSR value
out_exc  out  1  illegal-instruction exception
out_cause  out  XLEN  ILLEGAL_CAUSE when out_exc
out_tval  out  XLEN  in_inst when out_exc, else 0
flush  out  1  one-cycle pulse on non-exception response handshake
redirect_pc  out  XLEN  latched pc+4, valid with flush

Behaviour:
- Reset: state IDLE. in_ready=1. All other outputs are 0: csr_we, out_valid, flush, redirect_pc, and all latched fields.
- FSM: IDLE -> READ -> WRITE -> RESP -> IDLE.
- IDLE: on in_valid&in_ready, latch all in_* fields and cpu_mode; go to READ.
- READ (1 cycle):
  - csr_raddr = latched csr; capture csr_rdata into old_q.
  - Compute operand: src = zimm zero-extended (funct3[2]=1) or rs1_val.
  - wr_req = RW/RWI always; RS/RC/RSI/RCI only if rs1_idx!=0. The test is on the index, not the value.
  - new = RW: src; RS: old|src; RC: old&~src.
  - illegal = (csr[9:8] > cpu_mode) OR (csr[11:10]==2'b11 AND wr_req) OR funct3 in {000,100}.
- WRITE (1 cycle): csr_we = wr_req & ~illegal & ~kill; csr_waddr = csr; csr_wdata = new (registered in READ).
- RESP: out_valid=1, outputs held stable until out_ready. On handshake: return to IDLE; flush=1 for that cycle with redirect_pc=pc+4 (mod 2^XLEN) when ~illegal; no flush when illegal.
- Latency: accept at cycle 0, csr_we at cycle 2, out_valid from cycle 3. Throughput is one op per 4 cycles minimum.
- kill in READ or WRITE: return to IDLE, suppress csr_we, no response. kill in RESP is ignored because the write is already committed. kill in IDLE blocks acceptance that cycle.
- csr_raddr is driven only in READ and is 0 otherwise. csr_we is never high for more than one cycle per op.
- rst mid-operation: immediate return to IDLE with no write.
- rd==0: the CSR is still read (no read side effects exist) and out_rd_we=0.
- pc+4 wraps at 2^XLEN.

Decomposition:
- Shared package csr_exec_pkg holds:
  - enum csr_op_t over funct3 encodings
  - enum csr_exec_state_t {IDLE, READ, WRITE, RESP}
  - ILLEGAL_INST cause constant
  - privilege mode encodings, shared with the CSR file's cpu_mode_t
- One sub-module is natural: csr_alu, a combinational RW/RS/RC computation plus the wr_req and illegal checks. The FSM and registers stay in the top.

Test Plan:
- CSRRW, mode M, csr=0x340, rs1=5, val=0xDEADBEEF, old=0x12 -> cycle-2 we=1 waddr=0x340 wdata=0xDEADBEEF; rd_data=0x12; flush with redirect_pc=pc+4=0x80000104 for pc=0x80000100.
- CSRRS, rs1_idx=0, csr=0xF14 (read-only) -> no we, no exception, rd_data=mhartid, flush asserted.
- CSRRC, rs1 val=0x8, old=0xF on 0x300 -> wdata=0x7.
- CSRRWI to 0xC00 (read-only) -> out_exc=1, cause=2, tval=inst, we never high, no flush. Same test for cpu_mode=U accessing 0x300.
- kill asserted in READ -> no we, no out_valid, in_ready=1 next cycle. Repeat with rst in WRITE.
- out_ready held 0 for 5 cycles in RESP -> outputs stable, single flush pulse on the eventual handshake; pc=0xFFFFFFFC gives redirect 0x0.

Source files
------------

// File: rtl/csr_exec_unit_pkg.sv
// rtl/csr_exec_unit_pkg.sv - shared types and constants for the CSR execution unit
package csr_exec_pkg;

    typedef enum logic [2:0] {
        CSR_RW  = 3'b001,
        CSR_RS  = 3'b010,
        CSR_RC  = 3'b011,
        CSR_RWI = 3'b101,
        CSR_RSI = 3'b110,
        CSR_RCI = 3'b111
    } csr_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } csr_exec_state_t;

    // Same encoding as the CSR file's privilege mode type.
    typedef enum logic [1:0] {
        MODE_U = 2'd0,
        MODE_S = 2'd1,
        MODE_M = 2'd3
    } cpu_mode_t;

    localparam int ILLEGAL_INST = 2;

endpackage

// File: rtl/csr_exec_unit_if.sv
// rtl/csr_exec_unit_if.sv - commit-stage request, CSR file ports and writeback response
interface csr_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic [11:0]     in_csr;
    logic [4:0]      in_rs1_idx;
    logic [XLEN-1:0] in_rs1_val;
    logic [4:0]      in_rd_idx;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;
    logic [1:0]      cpu_mode;
    logic            kill;
    logic [11:0]     csr_raddr;
    logic [XLEN-1:0] csr_rdata;
    logic [11:0]     csr_waddr;
    logic            csr_we;
    logic [XLEN-1:0] csr_wdata;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_rd_idx;
    logic            out_rd_we;
    logic [XLEN-1:0] out_rd_data;
    logic            out_exc;
    logic [XLEN-1:0] out_cause;
    logic [XLEN-1:0] out_tval;
    logic            flush;
    logic [XLEN-1:0] redirect_pc;

    modport slave (
        input  in_valid, in_funct3, in_csr, in_rs1_idx, in_rs1_val, in_rd_idx,
               in_pc, in_inst, cpu_mode, kill, csr_rdata, out_ready,
        output in_ready, csr_raddr, csr_waddr, csr_we, csr_wdata, out_valid,
               out_rd_idx, out_rd_we, out_rd_data, out_exc, out_cause, out_tval,
               flush, redirect_pc
    );

    modport master (
        output in_valid, in_funct3, in_csr, in_rs1_idx, in_rs1_val, in_rd_idx,
               in_pc, in_inst, cpu_mode, kill, csr_rdata, out_ready,
        input  in_ready, csr_raddr, csr_waddr, csr_we, csr_wdata, out_valid,
               out_rd_idx, out_rd_we, out_rd_data, out_exc, out_cause, out_tval,
               flush, redirect_pc
    );
endinterface

// File: rtl/csr_exec_unit_alu.sv
// rtl/csr_exec_unit_alu.sv - read-modify-write value, write request and legality checks
module csr_alu
    import csr_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [11:0]     csr_i,
    input  logic [4:0]      rs1_idx_i,
    input  logic [XLEN-1:0] rs1_val_i,
    input  cpu_mode_t       mode_i,
    input  logic [XLEN-1:0] old_i,
    output logic [XLEN-1:0] new_o,
    output logic            wr_req_o,
    output logic            illegal_o
);
    logic [XLEN-1:0] src;
    logic            bad_op;

    always_comb begin
        src    = funct3_i[2] ? XLEN'(rs1_idx_i) : rs1_val_i;
        new_o  = src;
        bad_op = 1'b0;
        case (funct3_i)
            CSR_RW, CSR_RWI: new_o = src;
            CSR_RS, CSR_RSI: new_o = old_i | src;
            CSR_RC, CSR_RCI: new_o = old_i & ~src;
            default:         bad_op = 1'b1;
        endcase
        // Set/clear with x0 must not write, so read-only CSRs stay readable that way.
        wr_req_o  = (funct3_i[1:0] == 2'b01) || (rs1_idx_i != 5'd0);
        illegal_o = (csr_i[9:8] > mode_i) || ((csr_i[11:10] == 2'b11) && wr_req_o) || bad_op;
    end

endmodule

// File: rtl/csr_exec_unit.sv
// rtl/csr_exec_unit.sv - four-state Zicsr executor between commit stage and CSR file
module csr_exec_unit
    import csr_exec_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int ILLEGAL_CAUSE = ILLEGAL_INST
) (
    input logic          clk,
    input logic          rst,
    csr_exec_unit_if.slave bus
);
    csr_exec_state_t state_q, state_d;
    logic [2:0]      funct3_q;
    logic [11:0]     csr_q;
    logic [4:0]      rs1_idx_q;
    logic [XLEN-1:0] rs1_val_q;
    logic [4:0]      rd_idx_q;
    logic [31:0]     inst_q;
    cpu_mode_t       mode_q;
    logic [XLEN-1:0] redirect_q;
    logic [XLEN-1:0] old_q;
    logic [XLEN-1:0] new_q;
    logic            wr_req_q;
    logic            illegal_q;

    logic [XLEN-1:0] alu_new;
    logic            alu_wr_req;
    logic            alu_illegal;
    logic            accept;

    csr_alu #(.XLEN(XLEN)) u_alu (
        .funct3_i  (funct3_q),
        .csr_i     (csr_q),
        .rs1_idx_i (rs1_idx_q),
        .rs1_val_i (rs1_val_q),
        .mode_i    (mode_q),
        .old_i     (bus.csr_rdata),
        .new_o     (alu_new),
        .wr_req_o  (alu_wr_req),
        .illegal_o (alu_illegal)
    );

    assign accept = (state_q == IDLE) && bus.in_valid && !bus.kill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            funct3_q   <= '0;
            csr_q      <= '0;
            rs1_idx_q  <= '0;
            rs1_val_q  <= '0;
            rd_idx_q   <= '0;
            inst_q     <= '0;
            mode_q     <= MODE_U;
            redirect_q <= '0;
            old_q      <= '0;
            new_q      <= '0;
            wr_req_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                funct3_q   <= bus.in_funct3;
                csr_q      <= bus.in_csr;
                rs1_idx_q  <= bus.in_rs1_idx;
                rs1_val_q  <= bus.in_rs1_val;
                rd_idx_q   <= bus.in_rd_idx;
                inst_q     <= bus.in_inst;
                mode_q     <= cpu_mode_t'(bus.cpu_mode);
                redirect_q <= bus.in_pc + XLEN'(4);
            end
            if (state_q == READ) begin
                old_q     <= bus.csr_rdata;
                new_q     <= alu_new;
                wr_req_q  <= alu_wr_req;
                illegal_q <= alu_illegal;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.in_ready    = 1'b0;
        bus.csr_raddr   = '0;
        bus.csr_waddr   = '0;
        bus.csr_we      = 1'b0;
        bus.csr_wdata   = '0;
        bus.out_valid   = 1'b0;
        bus.out_rd_idx  = '0;
        bus.out_rd_we   = 1'b0;
        bus.out_rd_data = '0;
        bus.out_exc     = 1'b0;
        bus.out_cause   = '0;
        bus.out_tval    = '0;
        bus.flush       = 1'b0;
        bus.redirect_pc = redirect_q;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (accept) state_d = READ;
            end
            READ: begin
                bus.csr_raddr = csr_q;
                state_d       = bus.kill ? IDLE : WRITE;
            end
            WRITE: begin
                bus.csr_waddr = csr_q;
                bus.csr_wdata = new_q;
                bus.csr_we    = wr_req_q && !illegal_q && !bus.kill;
                state_d       = bus.kill ? IDLE : RESP;
            end
            RESP: begin
                // kill is ignored here: the CSR write has already landed.
                bus.out_valid   = 1'b1;
                bus.out_rd_idx  = rd_idx_q;
                bus.out_rd_we   = (rd_idx_q != 5'd0) && !illegal_q;
                bus.out_rd_data = old_q;
                bus.out_exc     = illegal_q;
                bus.out_cause   = illegal_q ? XLEN'(ILLEGAL_CAUSE) : '0;
                bus.out_tval    = illegal_q ? XLEN'(inst_q) : '0;
                if (bus.out_ready) begin
                    state_d   = IDLE;
                    bus.flush = !illegal_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
